ad5791_dac_writer: RTL and testbench

Avalon-ST sink to AD5791 20-bit DAC serial-interface driver. It sits directly downstream of the audio data path and drives one physical AD5791 conduit (`sync_n`, `sclk`, `mosi`, `ldac_n`, `clr_n`). Two instances are used, one for the left DAC and one for the right. After reset it clears and configures the DAC, then converts each accepted 24-bit sample into one 24-bit DAC-register write followed by an LDAC pulse.

---
 rtl/ad5791_dac_writer.sv | 161 ++++++++++++++++
 tb/tb_ad5791_dac_writer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ad5791_dac_writer.sv
// AD5791 20-bit DAC serial writer: Avalon-ST sample sink that clears and configures
// the DAC after reset, then sends one rounded 24-bit register write plus an LDAC pulse per sample.
module ad5791_dac_writer #(
    parameter int          SCLK_DIV   = 2,
    parameter int          CHANNEL    = 0,
    parameter int          CLR_CYCLES = 16,
    parameter logic [23:0] CTRL_WORD  = 24'h200002
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] avalon_sink_data,
    input  logic [1:0]  avalon_sink_channel,
    input  logic        avalon_sink_valid,
    output logic        avalon_sink_ready,
    output logic        ad5791_sync_n_out,
    output logic        ad5791_sclk_out,
    output logic        ad5791_mosi_out,
    output logic        ad5791_ldac_n_out,
    output logic        ad5791_clr_n_out,
    output logic        init_done
);

    localparam int              DW        = $clog2(SCLK_DIV + 1);
    localparam int              CW        = $clog2(CLR_CYCLES + 1);
    localparam logic [DW-1:0]   DIV_LAST  = DW'(SCLK_DIV - 1);
    localparam logic [CW-1:0]   CLR_LAST  = CW'(CLR_CYCLES - 1);
    localparam logic [5:0]      HALF_LAST = 6'd49;
    localparam logic [1:0]      MY_CH     = 2'(CHANNEL);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_CFG,
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_LDAC
    } state_t;

    state_t        state, nxt_state;
    logic [DW-1:0] div_cnt, nxt_div;
    logic [5:0]    half_cnt, nxt_half;
    logic [CW-1:0] clr_cnt, nxt_clr;
    logic [23:0]   shreg, nxt_shreg;
    logic          nxt_init, in_frame;
    logic          nxt_sync_n, nxt_sclk, nxt_mosi, nxt_ldac_n, nxt_clr_n, nxt_ready;
    logic [20:0]   rnd_sum;
    logic [19:0]   rnd_d;
    logic [23:0]   data_frame;

    // Round half up on the dropped nibble; only the positive side can overflow.
    always_comb begin
        rnd_sum    = {avalon_sink_data[23], avalon_sink_data[23:4]} + {20'd0, avalon_sink_data[3]};
        rnd_d      = (rnd_sum[20:19] == 2'b01) ? 20'h7FFFF : rnd_sum[19:0];
        data_frame = {4'b0001, rnd_d};
    end

    // Frame = 50 half-periods of D cycles: 0 setup, 1..48 bit halves (odd = sclk high), 49 hold.
    always_comb begin
        nxt_state = state;
        nxt_div   = div_cnt;
        nxt_half  = half_cnt;
        nxt_clr   = clr_cnt;
        nxt_shreg = shreg;
        nxt_init  = init_done;
        case (state)
            ST_CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    nxt_state = ST_CFG;
                    nxt_shreg = CTRL_WORD;
                    nxt_div   = '0;
                    nxt_half  = '0;
                end else begin
                    nxt_clr = clr_cnt + CW'(1);
                end
            end
            ST_CFG, ST_SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    nxt_div = '0;
                    if (half_cnt == HALF_LAST) begin
                        if (state == ST_CFG) begin
                            nxt_state = ST_IDLE;
                            nxt_init  = 1'b1;
                        end else begin
                            nxt_state = ST_GAP;
                        end
                    end else begin
                        nxt_half = half_cnt + 6'd1;
                        if (!half_cnt[0] && half_cnt != 6'd0)
                            nxt_shreg = {shreg[22:0], 1'b0};
                    end
                end else begin
                    nxt_div = div_cnt + DW'(1);
                end
            end
            ST_IDLE: begin
                if (avalon_sink_valid && avalon_sink_ready && avalon_sink_channel == MY_CH) begin
                    nxt_state = ST_SHIFT;
                    nxt_shreg = data_frame;
                    nxt_div   = '0;
                    nxt_half  = '0;
                end
            end
            ST_GAP: begin
                if (div_cnt == DIV_LAST) begin
                    nxt_div   = '0;
                    nxt_state = ST_LDAC;
                end else begin
                    nxt_div = div_cnt + DW'(1);
                end
            end
            ST_LDAC: begin
                if (div_cnt == DIV_LAST) begin
                    nxt_div   = '0;
                    nxt_state = ST_IDLE;
                end else begin
                    nxt_div = div_cnt + DW'(1);
                end
            end
            default: nxt_state = ST_CLEAR;
        endcase

        in_frame   = (nxt_state == ST_CFG) || (nxt_state == ST_SHIFT);
        nxt_sync_n = !in_frame;
        nxt_sclk   = in_frame && nxt_half[0] && (nxt_half != HALF_LAST);
        nxt_mosi   = in_frame && nxt_shreg[23];
        nxt_ldac_n = (nxt_state != ST_LDAC);
        nxt_clr_n  = (nxt_state != ST_CLEAR);
        nxt_ready  = (nxt_state == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_CLEAR;
            div_cnt           <= '0;
            half_cnt          <= '0;
            clr_cnt           <= '0;
            shreg             <= '0;
            init_done         <= 1'b0;
            ad5791_sync_n_out <= 1'b1;
            ad5791_sclk_out   <= 1'b0;
            ad5791_mosi_out   <= 1'b0;
            ad5791_ldac_n_out <= 1'b1;
            ad5791_clr_n_out  <= 1'b0;
            avalon_sink_ready <= 1'b0;
        end else begin
            state             <= nxt_state;
            div_cnt           <= nxt_div;
            half_cnt          <= nxt_half;
            clr_cnt           <= nxt_clr;
            shreg             <= nxt_shreg;
            init_done         <= nxt_init;
            ad5791_sync_n_out <= nxt_sync_n;
            ad5791_sclk_out   <= nxt_sclk;
            ad5791_mosi_out   <= nxt_mosi;
            ad5791_ldac_n_out <= nxt_ldac_n;
            ad5791_clr_n_out  <= nxt_clr_n;
            avalon_sink_ready <= nxt_ready;
        end
    end

endmodule

// File: tb/tb_ad5791_dac_writer.sv
// Directed bench for ad5791_dac_writer: two instances (CHANNEL 0 and 1) at D=2,
// frames captured on sclk falling edges and compared with hand-computed words.
module tb_ad5791_dac_writer;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] data0 = '0, data1 = '0;
    logic [1:0]  ch0 = '0, ch1 = '0;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic        ready0, sync0, sclk0, mosi0, ldac0, clr0, init0;
    logic        ready1, sync1, sclk1, mosi1, ldac1, clr1, init1;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int init_rise;
    int ldac0_lows = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (reset) init_rise <= -1;
        else if (init0 === 1'b1 && init_rise < 0) init_rise <= cyc;
    end
    always @(negedge clk) if (ldac0 === 1'b0) ldac0_lows <= ldac0_lows + 1;

    ad5791_dac_writer #(.SCLK_DIV(2), .CHANNEL(0), .CLR_CYCLES(16), .CTRL_WORD(24'h200002)) dut0 (
        .clk(clk), .reset(reset),
        .avalon_sink_data(data0), .avalon_sink_channel(ch0),
        .avalon_sink_valid(valid0), .avalon_sink_ready(ready0),
        .ad5791_sync_n_out(sync0), .ad5791_sclk_out(sclk0), .ad5791_mosi_out(mosi0),
        .ad5791_ldac_n_out(ldac0), .ad5791_clr_n_out(clr0), .init_done(init0)
    );

    ad5791_dac_writer #(.SCLK_DIV(2), .CHANNEL(1), .CLR_CYCLES(16), .CTRL_WORD(24'h200002)) dut1 (
        .clk(clk), .reset(reset),
        .avalon_sink_data(data1), .avalon_sink_channel(ch1),
        .avalon_sink_valid(valid1), .avalon_sink_ready(ready1),
        .ad5791_sync_n_out(sync1), .ad5791_sclk_out(sclk1), .ad5791_mosi_out(mosi1),
        .ad5791_ldac_n_out(ldac1), .ad5791_clr_n_out(clr1), .init_done(init1)
    );

    function automatic logic f_sync(input int w);  return (w != 0) ? sync1  : sync0;  endfunction
    function automatic logic f_sclk(input int w);  return (w != 0) ? sclk1  : sclk0;  endfunction
    function automatic logic f_mosi(input int w);  return (w != 0) ? mosi1  : mosi0;  endfunction
    function automatic logic f_ldac(input int w);  return (w != 0) ? ldac1  : ldac0;  endfunction
    function automatic logic f_ready(input int w); return (w != 0) ? ready1 : ready0; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic send(input int w, input logic [23:0] d, input logic [1:0] ch, input string tag);
        int g = 0;
        if (w == 0) begin data0 = d; ch0 = ch; valid0 = 1'b1; end
        else        begin data1 = d; ch1 = ch; valid1 = 1'b1; end
        while (f_ready(w) !== 1'b1 && g < 500) begin @(negedge clk); g++; end
        if (g >= 500) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        if (w == 0) valid0 = 1'b0; else valid1 = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; captures one sync_n-low frame, then watches post cycles.
    task automatic capture(input int w, input int post, output logic [23:0] frame,
                           output int low_cyc, output int ldac_cyc, output int ldac_start,
                           output int bits, output int mosi_bad);
        int   g = 0;
        logic prev_sclk = 1'b0;
        frame = '0; low_cyc = 0; ldac_cyc = 0; ldac_start = -1; bits = 0; mosi_bad = 0;
        while (f_sync(w) !== 1'b0 && g < 3000) begin @(negedge clk); g++; end
        if (g >= 3000) begin
            low_cyc = -1;
            return;
        end
        g = 0;
        while (f_sync(w) === 1'b0 && g < 3000) begin
            low_cyc++;
            if (prev_sclk === 1'b1 && f_sclk(w) === 1'b0) begin
                frame = {frame[22:0], f_mosi(w)};
                bits++;
            end
            prev_sclk = f_sclk(w);
            @(negedge clk);
            g++;
        end
        for (int k = 0; k < post; k++) begin
            if (f_sync(w) === 1'b1 && f_mosi(w) !== 1'b0) mosi_bad++;
            if (f_ldac(w) === 1'b0) begin
                if (ldac_start < 0) ldac_start = k;
                ldac_cyc++;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_init(input string pre);
        int c0, n, g, d;
        logic [23:0] fr;
        int lo, lc, ls, nb, mb;
        @(posedge clk); #1;
        reset = 1'b0;
        c0 = cyc;
        @(negedge clk);
        n = 0; g = 0;
        while (clr0 === 1'b0 && g < 500) begin n++; @(negedge clk); g++; end
        chk({pre, "_clr_low_cycles"}, n, 16);
        capture(0, 10, fr, lo, lc, ls, nb, mb);
        chk({pre, "_cfg_frame"}, {8'd0, fr}, {8'd0, 24'h200002});
        chk({pre, "_cfg_sync_low"}, lo, 100);
        chk({pre, "_cfg_bits"}, nb, 24);
        chk({pre, "_cfg_no_ldac"}, lc, 0);
        chk({pre, "_init_done"}, {31'd0, init0}, 32'd1);
        chk({pre, "_ready"}, {31'd0, ready0}, 32'd1);
        d = init_rise - c0;
        chk({pre, "_init_time_window"}, {31'd0, (d >= 116 && d <= 118)}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] fr;
        logic [23:0] bp_frames [3];
        int lo, lc, ls, nb, mb;
        int acc [3];
        int n_acc, g, rises, lows_before;
        logic prev;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sync_n", {31'd0, sync0}, 32'd1);
        chk("rst_sclk",   {31'd0, sclk0}, 32'd0);
        chk("rst_mosi",   {31'd0, mosi0}, 32'd0);
        chk("rst_ldac_n", {31'd0, ldac0}, 32'd1);
        chk("rst_clr_n",  {31'd0, clr0},  32'd0);
        chk("rst_ready",  {31'd0, ready0}, 32'd0);
        chk("rst_init",   {31'd0, init0}, 32'd0);

        do_init("init");

        // Rounding and frame timing
        send(0, 24'h12345F, 2'd0, "round");
        capture(0, 10, fr, lo, lc, ls, nb, mb);
        chk("round_frame", {8'd0, fr}, {8'd0, 24'h112346});
        chk("round_sync_low", lo, 100);
        chk("round_bits", nb, 24);
        chk("round_ldac_cycles", lc, 2);
        chk("round_ldac_start", ls, 2);
        chk("round_mosi_idle_zero", mb, 0);

        // Saturation and negative full scale
        send(0, 24'h7FFFF8, 2'd0, "sat_pos");
        capture(0, 4, fr, lo, lc, ls, nb, mb);
        chk("sat_pos_frame", {8'd0, fr}, {8'd0, 24'h17FFFF});
        send(0, 24'h800000, 2'd0, "neg_fs");
        capture(0, 4, fr, lo, lc, ls, nb, mb);
        chk("neg_fs_frame", {8'd0, fr}, {8'd0, 24'h180000});
        send(0, 24'hFFFFF7, 2'd0, "neg_small");
        capture(0, 4, fr, lo, lc, ls, nb, mb);
        chk("neg_small_frame", {8'd0, fr}, {8'd0, 24'h1FFFFF});

        // Channel filter on the CHANNEL=1 instance
        data1 = 24'h400000; ch1 = 2'd0; valid1 = 1'b1;
        chk("chan_ready_pre", {31'd0, ready1}, 32'd1);
        @(posedge clk); #1;
        data1 = 24'h000010; ch1 = 2'd1;
        @(negedge clk);
        chk("chan_drop_ready", {31'd0, ready1}, 32'd1);
        chk("chan_drop_no_frame", {31'd0, sync1}, 32'd1);
        @(posedge clk); #1;
        valid1 = 1'b0;
        @(negedge clk);
        capture(1, 4, fr, lo, lc, ls, nb, mb);
        chk("chan_frame", {8'd0, fr}, {8'd0, 24'h100001});
        chk("chan_sync_low", lo, 100);
        lo = 0;
        for (int k = 0; k < 150; k++) begin
            if (sync1 === 1'b0) lo++;
            @(negedge clk);
        end
        chk("chan_single_frame", lo, 0);

        // Backpressure: valid held high across three samples
        data0 = 24'h000008; ch0 = 2'd0; valid0 = 1'b1;
        n_acc = 0;
        for (int n = 0; n < 3; n++) begin
            g = 0;
            while (ready0 !== 1'b1 && g < 500) begin @(negedge clk); g++; end
            if (ready0 === 1'b1) begin
                acc[n] = cyc;
                n_acc++;
            end
            @(posedge clk); #1;
            if (n == 0) data0 = 24'hFFFFF8;
            else if (n == 1) data0 = 24'h7FFFF0;
            else valid0 = 1'b0;
            @(negedge clk);
            capture(0, 3, fr, lo, lc, ls, nb, mb);
            bp_frames[n] = fr;
        end
        chk("bp_accept_count", n_acc, 3);
        chk("bp_spacing_1", acc[1] - acc[0], 105);
        chk("bp_spacing_2", acc[2] - acc[1], 105);
        chk("bp_frame_0", {8'd0, bp_frames[0]}, {8'd0, 24'h100001});
        chk("bp_frame_1", {8'd0, bp_frames[1]}, {8'd0, 24'h100000});
        chk("bp_frame_2", {8'd0, bp_frames[2]}, {8'd0, 24'h17FFFF});
        repeat (4) @(negedge clk);

        // Reset in the middle of a data frame (bit 10)
        send(0, 24'h0ABCD0, 2'd0, "midrst");
        rises = 0; g = 0; prev = 1'b0;
        while (g < 500) begin
            if (prev === 1'b0 && sclk0 === 1'b1) rises++;
            if (rises == 11) break;
            prev = sclk0;
            @(negedge clk);
            g++;
        end
        chk("midrst_reached_bit10", rises, 11);
        lows_before = ldac0_lows;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_sync_n", {31'd0, sync0}, 32'd1);
        chk("midrst_sclk",   {31'd0, sclk0}, 32'd0);
        chk("midrst_mosi",   {31'd0, mosi0}, 32'd0);
        chk("midrst_clr_n",  {31'd0, clr0},  32'd0);
        chk("midrst_ready",  {31'd0, ready0}, 32'd0);
        chk("midrst_ldac_n", {31'd0, ldac0}, 32'd1);
        chk("midrst_init",   {31'd0, init0}, 32'd0);
        do_init("reinit");
        @(posedge clk); #1;
        chk("midrst_no_ldac_pulse", ldac0_lows - lows_before, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
